// File: rtl/vde_pkg.sv
// Shared types and default sizing for the video display engine fetch path.
package vde_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_ABORT
    } vde_fetch_state_t;

    localparam int unsigned VDE_LINE_WORDS      = 20;
    localparam int unsigned VDE_FIFO_DEPTH      = 15;
    localparam int unsigned VDE_MAX_OUTSTANDING = 4;

    function automatic int unsigned vde_cnt_width(input int unsigned limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/vde_credit_counter.sv
// Up/down credit counter: one increment and up to two decrements per cycle,
// saturating at zero (an underflow is a protocol error and trips an assertion).
module vde_credit_counter
    import vde_pkg::*;
#(
    parameter  int unsigned LIMIT = 4,
    localparam int unsigned W     = vde_cnt_width(LIMIT)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic [1:0]   dec_i,
    output logic [W-1:0] count_o,
    output logic         at_limit_o
);

    logic [W-1:0] r_count;
    logic [W:0]   w_sum;
    logic [W:0]   w_dec;
    logic         w_underflow;
    logic [W-1:0] w_next;

    always_comb begin
        w_dec       = (W+1)'(dec_i);
        w_sum       = {1'b0, r_count} + (W+1)'(inc_i);
        w_underflow = w_dec > {1'b0, r_count};
        // Underflow clamps the decrement to the current count.
        if (w_underflow) begin
            w_next = W'(inc_i);
        end else begin
            w_next = W'(w_sum - w_dec);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else begin
            assert (!w_underflow);
            r_count <= w_next;
        end
    end

    assign count_o    = r_count;
    assign at_limit_o = (r_count >= W'(LIMIT));

endmodule

// File: rtl/vde_fetch_sched.sv
// Line-fetch scheduler: issues one word read per 4 pixels under FIFO/outstanding credit.
// Optional underrun statistics are built with VDE_FETCH_STATS_EN.
module vde_fetch_sched
    import vde_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 16,
    parameter int unsigned LINE_WORDS      = VDE_LINE_WORDS,
    parameter int unsigned FIFO_DEPTH      = VDE_FIFO_DEPTH,
    parameter int unsigned MAX_OUTSTANDING = VDE_MAX_OUTSTANDING
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  line_start_i,
    input  logic [ADDR_WIDTH-1:0] line_base_i,
    input  logic                  abort_i,
    output logic                  busy_o,
    output logic                  line_done_o,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
    input  logic                  mem_rsp_valid_i,
    output logic                  fifo_wr_valid_o,
    input  logic                  fifo_word_pop_i
`ifdef VDE_FETCH_STATS_EN
    ,
    input  logic                  fifo_empty_i,
    input  logic                  sink_ready_i,
    output logic [15:0]           underrun_cnt_o
`endif
);

    localparam int unsigned OCC_W   = vde_cnt_width(FIFO_DEPTH);
    localparam int unsigned OUTST_W = vde_cnt_width(MAX_OUTSTANDING);

    vde_fetch_state_t      r_state;
    vde_fetch_state_t      w_state_next;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [7:0]            r_word_idx;
    logic                  r_line_done;

    logic                  w_issue;
    logic                  w_hs;
    logic                  w_last_hs;
    logic                  w_discard;
    logic                  w_drained;
    logic                  w_done_set;
    logic [1:0]            w_occ_dec;
    logic [OCC_W-1:0]      w_occ_count;
    logic                  w_occ_at_limit;
    logic [OUTST_W-1:0]    w_outst_count;
    logic                  w_outst_at_limit;
    logic                  w_unused_occ_count;

    assign w_issue   = (r_state == ST_FETCH) && !w_occ_at_limit && !w_outst_at_limit;
    assign w_hs      = w_issue && mem_req_ready_i;
    assign w_last_hs = w_hs && (r_word_idx == 8'(LINE_WORDS - 1));
    assign w_discard = (r_state == ST_ABORT);
    assign w_occ_dec = {1'b0, fifo_word_pop_i} + {1'b0, w_discard && mem_rsp_valid_i};
    // True when the outstanding count is zero after this cycle's response.
    assign w_drained = (w_outst_count == '0) ||
                       ((w_outst_count == OUTST_W'(1)) && mem_rsp_valid_i);
    assign w_unused_occ_count = ^w_occ_count;

    vde_credit_counter #(.LIMIT(FIFO_DEPTH)) u_occ (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .inc_i      (w_hs),
        .dec_i      (w_occ_dec),
        .count_o    (w_occ_count),
        .at_limit_o (w_occ_at_limit)
    );

    vde_credit_counter #(.LIMIT(MAX_OUTSTANDING)) u_outst (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .inc_i      (w_hs),
        .dec_i      ({1'b0, mem_rsp_valid_i}),
        .count_o    (w_outst_count),
        .at_limit_o (w_outst_at_limit)
    );

    always_comb begin
        w_state_next = r_state;
        w_done_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (line_start_i) w_state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (abort_i)        w_state_next = ST_ABORT;
                else if (w_last_hs) w_state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (abort_i) begin
                    w_state_next = ST_ABORT;
                end else if (w_drained) begin
                    w_state_next = ST_IDLE;
                    w_done_set   = 1'b1;
                end
            end
            ST_ABORT: begin
                if (w_drained) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_base      <= '0;
            r_word_idx  <= '0;
            r_line_done <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_line_done <= w_done_set;
            if (r_state == ST_IDLE && line_start_i) begin
                r_base     <= line_base_i;
                r_word_idx <= '0;
            end else if (w_hs) begin
                r_word_idx <= r_word_idx + 8'd1;
            end
        end
    end

    assign busy_o          = (r_state != ST_IDLE);
    assign line_done_o     = r_line_done;
    assign mem_req_valid_o = w_issue;
    assign mem_req_addr_o  = r_base + ADDR_WIDTH'(r_word_idx);
    assign fifo_wr_valid_o = mem_rsp_valid_i && ((r_state == ST_FETCH) || (r_state == ST_DRAIN));

`ifdef VDE_FETCH_STATS_EN
    logic [15:0] r_underrun_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_underrun_cnt <= '0;
        end else if (busy_o && sink_ready_i && fifo_empty_i && (r_underrun_cnt != '1)) begin
            r_underrun_cnt <= r_underrun_cnt + 16'd1;
        end
    end

    assign underrun_cnt_o = r_underrun_cnt;
`endif

endmodule

// File: doc/vde_fetch_sched.md
# vde_fetch_sched

Line-fetch scheduler for the video display engine. On each line start it issues one 32-bit word read per 4 pixels to the memory port and steers the in-order responses into the 16-entry 4-byte pixel FIFO. It keeps a credit count so that issued-but-unread words never exceed FIFO capacity, and it handles line aborts by discarding responses still in flight.

## Interface
- `ADDR_WIDTH`, 16: word address width.
- `LINE_WORDS`, 20: words fetched per line, range 1..255.
- `FIFO_DEPTH`, 15: usable FIFO entries (16-slot FIFO, one slot kept empty).
- `MAX_OUTSTANDING`, 4: maximum number of requests in flight without a response.
- `clk_i` in 1: sole clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `line_start_i` in 1: one-cycle pulse that starts a line fetch.
- `line_base_i` in ADDR_WIDTH: word address of the line; sampled with `line_start_i`.
- `abort_i` in 1: pulse that cancels the current line.
- `busy_o` out 1: high whenever the FSM is not in IDLE.
- `line_done_o` out 1: one-cycle pulse when the last response of a line has been written to the FIFO.
- `mem_req_valid_o` out 1, `mem_req_ready_i` in 1, `mem_req_addr_o` out ADDR_WIDTH: read request channel.
- `mem_rsp_valid_i` in 1: response beat. Responses arrive in order and cannot be stalled.
- `fifo_wr_valid_o` out 1: FIFO push strobe, equal to `mem_rsp_valid_i` gated by discard.
- `fifo_word_pop_i` in 1: pulse when the FIFO retires a full 4-byte word (4th byte handshake).
- `underrun_cnt_o` out 16: present only with `VDE_FETCH_STATS_EN`.
- `fifo_empty_i`, `sink_ready_i` in 1: present only with `VDE_FETCH_STATS_EN`.

## Operation
- FSM states: IDLE, FETCH, DRAIN, ABORT.
- IDLE→FETCH: on `line_start_i`. Latch `line_base_i`; clear `word_idx`.
- FETCH: issue allowed when `occ < FIFO_DEPTH` and `outst < MAX_OUTSTANDING`.
  - `mem_req_valid_o` = issue allowed.
  - `mem_req_addr_o` = `base + word_idx`, wrapping modulo 2^ADDR_WIDTH.
  - Each handshake increments `word_idx`, `occ` and `outst`.
- FETCH→DRAIN: on the handshake that takes `word_idx` to LINE_WORDS.
- DRAIN→IDLE: when `outst` reaches 0 after the last response. `line_done_o` pulses on the next cycle.
- Any non-IDLE state →ABORT: on `abort_i`. Request issue stops at once.
- ABORT: responses are counted but `fifo_wr_valid_o` = 0. Each discarded response decrements `occ` and `outst`. ABORT→IDLE when `outst` = 0; no `line_done_o` is produced.
- Counter updates:
  - `outst` decrements on every `mem_rsp_valid_i`.
  - `occ` decrements on `fifo_word_pop_i` and on each discarded response.
  - A simultaneous increment and decrement on the same counter leaves it unchanged.
- Out-of-state inputs:
  - `line_start_i` outside IDLE is ignored.
  - `abort_i` in IDLE is a no-op.
  - If `abort_i` and `line_start_i` arrive together in IDLE, the start is taken.
- Protocol errors: a response with `outst` = 0, or a pop with `occ` = 0, is a protocol error. The counters saturate at 0 and an assertion fires in simulation.
- FIFO words already written before an abort remain in the FIFO. The display engine flushes them through its own reset.

## Timing
- Reset values: state IDLE, all counters 0, every output 0.
- Start latency: `mem_req_valid_o` can first be high in the cycle after `line_start_i`.
- Request channel rules:
  - `valid` and `addr` hold stable until `ready`.
  - The only permitted drop of `valid` without a handshake is the cycle after `abort_i`.
- `fifo_wr_valid_o` is combinational from `mem_rsp_valid_i` (zero latency).
- Throughput: with `mem_req_ready_i` held high and response latency ≤ MAX_OUTSTANDING cycles, one request issues per cycle.
- `busy_o` and `line_done_o` are registered.
- `rst_i` asserted mid-line returns the FSM to IDLE on the next edge and drops all counters. The memory side must also be reset.

## Configuration
- Macro: `VDE_FETCH_STATS_EN`.
- With the macro defined, the block adds `fifo_empty_i`, `sink_ready_i` and `underrun_cnt_o`.
  - `underrun_cnt_o` is a saturating 16-bit counter.
  - It increments each cycle that `busy_o && sink_ready_i && fifo_empty_i` holds.
  - It clears only on `rst_i`.
- Without the macro, those three ports and the counter do not exist; all other behaviour is identical.

## Structure
- Shared package `vde_pkg`:
  - FSM state enum `vde_fetch_state_t`.
  - Default constants: `VDE_LINE_WORDS`, `VDE_FIFO_DEPTH`, `VDE_MAX_OUTSTANDING`.
- Sub-module `vde_credit_counter`:
  - Parameterised up/down counter with `inc`, `dec`, `count` and `at_limit` outputs.
  - Saturates at 0, asserts on underflow.
  - Instantiated twice: once for `occ`, once for `outst`.

## Test plan
Parameters for all scenarios: defaults, response latency 2 cycles.
- Basic line: base 0x1000, no pops, ready held high → exactly 15 requests (addresses 0x1000–0x100E), then `valid` stays low. 5 pops → 5 more requests to 0x100F–0x1013, then `line_done_o` pulses once.
- Address wrap: base 0xFFFE → addresses 0xFFFE, 0xFFFF, 0x0000, … for 20 words.
- Backpressure: `mem_req_ready_i` low for 10 cycles → `valid` and `addr` held constant; `outst` never exceeds 4 once ready returns.
- Abort mid-line with 3 outstanding: `abort_i` → `fifo_wr_valid_o` stays 0 for those 3 responses, `busy_o` falls after the 3rd, no `line_done_o`.
- Edge-case inputs: `line_start_i` during FETCH is ignored (address sequence unchanged). `rst_i` mid-DRAIN → all outputs 0 next cycle.
- `VDE_FETCH_STATS_EN` build: hold `fifo_empty_i` = `sink_ready_i` = 1 for 7 busy cycles → `underrun_cnt_o` = 7. Also check that the counter saturates at 0xFFFF.
